// File: rtl/noc_pkg.sv
// noc_pkg: shared packet layout and field widths for the ring NoC
package noc_pkg;
   localparam int TS_W = 16;
   localparam int ID_W = 16;
   localparam int PACKET_SIZE = 1 + TS_W + 2 * ID_W;
   typedef struct packed {
      logic            vld;
      logic [TS_W-1:0] ts;
      logic [ID_W-1:0] src;
      logic [ID_W-1:0] dst;
   } packet_t;
endpackage

// File: rtl/noc_sync_fifo.sv
// noc_sync_fifo: single-clock FIFO, any depth, pointers wrap by compare
module noc_sync_fifo #(
   parameter int WIDTH = 8,
   parameter int DEPTH = 4,
   localparam int PW = DEPTH > 1 ? $clog2(DEPTH) : 1,
   localparam int CW = $clog2(DEPTH + 1)
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             push,
   input  logic             pop,
   input  logic [WIDTH-1:0] din,
   output logic [WIDTH-1:0] dout,
   output logic             full,
   output logic             empty,
   output logic [CW-1:0]    count
);
   logic [WIDTH-1:0] mem [DEPTH];
   logic [PW-1:0]    wr_ptr, rd_ptr;
   logic             do_push, do_pop;
   assign full    = count == CW'(DEPTH);
   assign empty   = count == '0;
   assign do_push = push && !full;
   assign do_pop  = pop && !empty;
   assign dout    = mem[rd_ptr];
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (do_push) wr_ptr <= wr_ptr == PW'(DEPTH - 1) ? '0 : wr_ptr + PW'(1);
         if (do_pop) rd_ptr <= rd_ptr == PW'(DEPTH - 1) ? '0 : rd_ptr + PW'(1);
         count <= count + CW'(do_push) - CW'(do_pop);
      end
   end
   always_ff @(posedge clk) begin
      if (do_push) mem[wr_ptr] <= din;
   end
endmodule

// File: rtl/packet_eject_local.sv
// packet_eject_local: local ejection sink, buffers arrivals, drains at a fixed rate, keeps latency stats
module packet_eject_local import noc_pkg::*; #(
   parameter int NUM_NODES            = 8,
   parameter int ROUTER_ID            = 0,
   parameter int BUFFER_SIZE          = 4,
   parameter int EJECT_CYCLE          = 1,
   parameter int NUM_PACKETS_PER_NODE = 20
) (
   input  logic                   clk,
   input  logic                   rst_n,
   input  logic [TS_W-1:0]        clk_counter,
   input  logic                   packet_valid,
   input  logic [PACKET_SIZE-1:0] packet_in,
   output logic                   packet_ready,
   output logic [63:0]            total_packet_recv,
   output logic [63:0]            total_latency,
   output logic [15:0]            max_latency,
   output logic [15:0]            dst_err_cnt,
   output logic                   all_received
);
   localparam int DW = EJECT_CYCLE > 1 ? $clog2(EJECT_CYCLE) : 1;
   localparam int CW = $clog2(BUFFER_SIZE + 1);
   packet_t           pkt_in, head;
   logic [PACKET_SIZE-1:0] head_bits;
   logic [CW-1:0]     fifo_count;
   logic [DW-1:0]     drain_cnt;
   logic              full, empty, push, pop, tick;
   logic [TS_W-1:0]   latency;
   logic              unused_ok;
   assign pkt_in       = packet_in;
   assign head         = head_bits;
   assign packet_ready = !full;
   assign push         = packet_valid && packet_ready && pkt_in.vld;
   assign tick         = drain_cnt == DW'(EJECT_CYCLE - 1);
   assign pop          = tick && !empty;
   assign latency      = clk_counter - head.ts;
   assign unused_ok    = ^{head.vld, head.src, fifo_count} ^ (ROUTER_ID < NUM_NODES);
   noc_sync_fifo #(.WIDTH(PACKET_SIZE), .DEPTH(BUFFER_SIZE)) u_fifo (
      .clk   (clk),
      .rst_n (rst_n),
      .push  (push),
      .pop   (pop),
      .din   (packet_in),
      .dout  (head_bits),
      .full  (full),
      .empty (empty),
      .count (fifo_count)
   );
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) drain_cnt <= '0;
      else drain_cnt <= tick ? '0 : drain_cnt + DW'(1);
   end
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         total_packet_recv <= '0;
         total_latency     <= '0;
         max_latency       <= '0;
         dst_err_cnt       <= '0;
         all_received      <= 1'b0;
      end else if (pop) begin
         total_packet_recv <= total_packet_recv + 64'd1;
         total_latency     <= total_latency + 64'(latency);
         max_latency       <= latency > max_latency ? latency : max_latency;
         if (head.dst != ID_W'(ROUTER_ID) && dst_err_cnt != 16'hFFFF) dst_err_cnt <= dst_err_cnt + 16'd1;
         all_received <= all_received || (total_packet_recv + 64'd1 >= 64'(NUM_PACKETS_PER_NODE));
      end
   end
endmodule

// File: tb/tb_packet_eject_local.sv
// tb_packet_eject_local: directed checks on a rate-1 and a rate-4 ejection sink
module tb_packet_eject_local;
   logic        clk, rst_n;
   logic [15:0] clk_counter;
   logic        f_valid, s_valid;
   logic [48:0] f_pkt, s_pkt;
   logic        f_ready, s_ready, f_all, s_all;
   logic [63:0] f_recv, f_total, s_recv, s_total;
   logic [15:0] f_max, f_err, s_max, s_err;
   int vectors = 0;
   int miscompares = 0;

   packet_eject_local #(.NUM_NODES(8), .ROUTER_ID(3), .BUFFER_SIZE(4), .EJECT_CYCLE(1),
                        .NUM_PACKETS_PER_NODE(20)) u_fast (
      .clk(clk), .rst_n(rst_n), .clk_counter(clk_counter), .packet_valid(f_valid), .packet_in(f_pkt),
      .packet_ready(f_ready), .total_packet_recv(f_recv), .total_latency(f_total),
      .max_latency(f_max), .dst_err_cnt(f_err), .all_received(f_all));

   packet_eject_local #(.NUM_NODES(8), .ROUTER_ID(3), .BUFFER_SIZE(4), .EJECT_CYCLE(4),
                        .NUM_PACKETS_PER_NODE(20)) u_slow (
      .clk(clk), .rst_n(rst_n), .clk_counter(clk_counter), .packet_valid(s_valid), .packet_in(s_pkt),
      .packet_ready(s_ready), .total_packet_recv(s_recv), .total_latency(s_total),
      .max_latency(s_max), .dst_err_cnt(s_err), .all_received(s_all));

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #200000;
      $display("FAIL watchdog: observed timeout, required finish");
      $fatal(1, "timeout");
   end

   function automatic logic [48:0] mk(input logic v, input logic [15:0] ts, src, dst);
      return {v, ts, src, dst};
   endfunction

   // one clock: the counter advances just after the edge and stays stable up to the next one
   task automatic cyc();
      @(posedge clk);
      #1;
      clk_counter = clk_counter + 16'd1;
   endtask

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      vectors++;
      assert (obs === exp) else begin
         miscompares++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   initial begin
      rst_n = 1'b0; clk_counter = '0;
      f_valid = 1'b0; s_valid = 1'b0; f_pkt = '0; s_pkt = '0;
      cyc(); cyc();
      chk("rst_recv", f_recv, 0);
      chk("rst_total", f_total, 0);
      chk("rst_max", f_max, 0);
      chk("rst_err", f_err, 0);
      chk("rst_ready", f_ready, 1);
      chk("rst_all", f_all, 0);
      chk("rst_s_ready", s_ready, 1);
      chk("rst_s_recv", s_recv, 0);

      // backpressure: pops at cycles 3,7,11..., ready low while four entries held
      rst_n = 1'b1;
      s_valid = 1'b1;
      for (int i = 0; i < 28; i++) begin
         chk($sformatf("bp_ready[%0d]", i), s_ready, 64'((i < 4) || (i % 4 == 0)));
         chk($sformatf("bp_recv[%0d]", i), s_recv, 64'(i / 4));
         s_pkt = mk(1'b1, clk_counter, 16'(i), 16'd3);
         cyc();
      end
      s_valid = 1'b0;
      chk("bp_recv_end", s_recv, 7);
      chk("bp_total", s_total, 75);
      chk("bp_max", s_max, 15);
      chk("bp_err", s_err, 0);
      chk("bp_all", s_all, 0);

      // reset while the slow FIFO still holds packets
      rst_n = 1'b0;
      cyc();
      chk("mid_rst_recv", s_recv, 0);
      chk("mid_rst_total", s_total, 0);
      chk("mid_rst_max", s_max, 0);
      chk("mid_rst_ready", s_ready, 1);
      rst_n = 1'b1;
      repeat (6) cyc();
      chk("mid_rst_drained", s_recv, 0);
      chk("mid_rst_ready2", s_ready, 1);
      chk("mid_rst_f_recv", f_recv, 0);

      // single packet: push at counter 12, pop at 13
      clk_counter = 16'd12;
      f_valid = 1'b1; f_pkt = mk(1'b1, 16'd10, 16'd4, 16'd3);
      cyc();
      f_valid = 1'b0;
      chk("single_pop_cycle_recv", f_recv, 0);
      cyc();
      chk("single_recv", f_recv, 1);
      chk("single_total", f_total, 3);
      chk("single_max", f_max, 3);
      chk("single_err", f_err, 0);

      // timestamp wrap: ts=FFFE popped at counter 3
      clk_counter = 16'd2;
      f_valid = 1'b1; f_pkt = mk(1'b1, 16'hFFFE, 16'd4, 16'd3);
      cyc();
      f_valid = 1'b0;
      cyc();
      chk("wrap_recv", f_recv, 2);
      chk("wrap_total", f_total, 8);
      chk("wrap_max", f_max, 5);

      // wrong destination, then an offered vld=0 packet
      f_valid = 1'b1; f_pkt = mk(1'b1, clk_counter, 16'd4, 16'd5);
      cyc();
      f_valid = 1'b0;
      cyc();
      chk("dst_recv", f_recv, 3);
      chk("dst_err", f_err, 1);
      chk("dst_total", f_total, 9);
      f_valid = 1'b1; f_pkt = mk(1'b0, clk_counter, 16'd4, 16'd3);
      cyc(); cyc();
      f_valid = 1'b0;
      cyc();
      chk("novld_recv", f_recv, 3);
      chk("novld_err", f_err, 1);
      chk("novld_total", f_total, 9);

      // completion: 16 back-to-back then packets 20 and 21
      f_valid = 1'b1;
      for (int i = 0; i < 16; i++) begin
         f_pkt = mk(1'b1, clk_counter, 16'd4, 16'd3);
         cyc();
      end
      f_valid = 1'b0;
      cyc();
      chk("done_recv19", f_recv, 19);
      chk("done_all19", f_all, 0);
      f_valid = 1'b1; f_pkt = mk(1'b1, clk_counter, 16'd4, 16'd3);
      cyc();
      f_valid = 1'b0;
      chk("done_all_pre", f_all, 0);
      cyc();
      chk("done_recv20", f_recv, 20);
      chk("done_all20", f_all, 1);
      f_valid = 1'b1; f_pkt = mk(1'b1, clk_counter, 16'd4, 16'd3);
      cyc();
      f_valid = 1'b0;
      cyc();
      chk("done_recv21", f_recv, 21);
      chk("done_all21", f_all, 1);
      chk("done_total", f_total, 27);
      chk("done_max", f_max, 5);
      chk("done_err", f_err, 1);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end
endmodule
